// File: rtl/accel_axis_filter_pkg.sv
// accel_pkg: shared types and helpers for the accelerometer moving-average filter.
//   - state_e   : filter sequencer states (IDLE, ACCUM, PUBLISH)
//   - AXIS_X/Y/Z: axis index constants for the default 3-axis build
//   - sum_width : width of a per-axis running sum (sample width + averaging log2)
package accel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    PUBLISH = 2'd2
  } state_e;

  localparam int AXIS_X = 0;
  localparam int AXIS_Y = 1;
  localparam int AXIS_Z = 2;

  // A sum of 2^avg_log2 samples of data_w bits needs avg_log2 guard bits.
  function automatic int sum_width(input int data_w, input int avg_log2);
    return data_w + avg_log2;
  endfunction

endpackage

// File: rtl/accel_axis_filter_if.sv
// accel_axis_filter_if: sample-in / average-out bus of the accelerometer filter.
//   slave  : seen by the filter (takes samples, drives results)
//   master : seen by the sample source / result consumer
// Signals:
//   sample_valid, sample_data  - one-cycle sample strobe and packed samples
//   in_ready                   - filter idle, can take a sample
//   out_valid                  - one-cycle strobe, results updated
//   avg_data, abs_data         - packed per-axis average and its magnitude
//   neg, over                  - per-axis sign and threshold flags
//   filled                     - averaging window fully populated
//   overrun_cnt                - saturating count of dropped samples
interface accel_axis_filter_if #(
  parameter int DATA_W = 16,
  parameter int N_AXES = 3
);
  logic                       sample_valid;
  logic [N_AXES*DATA_W-1:0]   sample_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [N_AXES*DATA_W-1:0]   avg_data;
  logic [N_AXES*DATA_W-1:0]   abs_data;
  logic [N_AXES-1:0]          neg;
  logic [N_AXES-1:0]          over;
  logic                       filled;
  logic [7:0]                 overrun_cnt;

  modport slave (
    input  sample_valid, sample_data,
    output in_ready, out_valid, avg_data, abs_data, neg, over, filled, overrun_cnt
  );

  modport master (
    output sample_valid, sample_data,
    input  in_ready, out_valid, avg_data, abs_data, neg, over, filled, overrun_cnt
  );
endinterface

// File: rtl/accel_axis_filter_ram.sv
// accel_sample_ram: history buffer for the moving average, DEPTH x DATA_W.
// One shared address for read and write; the read is combinational, so in
// the cycle of a write it returns the entry being replaced (old data).
// The whole array clears on reset so the average ramps up from zero.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   we_i      - write enable
//   addr_i    - entry address ({axis, ptr})
//   wdata_i   - new sample
//   rdata_o   - current (pre-write) content of addr_i
module accel_sample_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 24,
  parameter int AW     = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/accel_axis_filter.sv
// accel_axis_filter: per-axis moving average over 2^AVG_LOG2 samples.
// A sample is captured in IDLE, each axis is folded into its running sum in
// one ACCUM cycle (sum += new - oldest), then PUBLISH presents average,
// magnitude, sign and threshold flags with a one-cycle out_valid.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - accel_axis_filter_if.slave (sample in, results out)
// Build option: ACCEL_FILT_HYST_EN adds a hysteresis band of HYST below
// THRESH to the over flags; without it over is a plain abs > THRESH.
module accel_axis_filter
  import accel_pkg::*;
#(
  parameter int          DATA_W   = 16,
  parameter int          N_AXES   = 3,
  parameter int          AVG_LOG2 = 3,
  parameter int unsigned THRESH   = 32'h1000,
  parameter int unsigned HYST     = 32'h0100
) (
  input  logic               clk,
  input  logic               rst,
  accel_axis_filter_if.slave bus
);

  localparam int D     = 1 << AVG_LOG2;
  localparam int SUM_W = sum_width(DATA_W, AVG_LOG2);
  localparam int KW    = (N_AXES > 1) ? $clog2(N_AXES) : 1;
  localparam int FW    = AVG_LOG2 + 1;
  localparam int DEPTH = N_AXES * D;
  localparam int AW    = $clog2(DEPTH);

  localparam logic [DATA_W-1:0] TH      = DATA_W'(THRESH);
  localparam logic [DATA_W-1:0] TH_LO   = DATA_W'(THRESH - HYST);
  localparam logic [DATA_W-1:0] AVG_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] AVG_MAX = {1'b0, {(DATA_W-1){1'b1}}};

`ifdef ACCEL_FILT_HYST_EN
  localparam bit HYST_ON = 1'b1;
`else
  localparam bit HYST_ON = 1'b0;
`endif

  // sequencer state
  state_e                         state_q;
  logic [KW-1:0]                  k_q;
  logic [AVG_LOG2-1:0]            ptr_q;
  logic [FW-1:0]                  fill_q;
  logic [N_AXES-1:0][DATA_W-1:0]  cap_q;
  logic [SUM_W-1:0]               sum_q [N_AXES];
  logic [SUM_W-1:0]               sum_d [N_AXES];

  // registered outputs
  logic                           in_ready_q;
  logic                           out_valid_q;
  logic [N_AXES-1:0][DATA_W-1:0]  avg_q, avg_d;
  logic [N_AXES-1:0][DATA_W-1:0]  abs_q, abs_d;
  logic [N_AXES-1:0]              neg_q, neg_d;
  logic [N_AXES-1:0]              over_q, over_d;
  logic                           filled_q;
  logic [7:0]                     ovr_q;

  // history buffer
  logic              ram_we;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  assign ram_we    = (state_q == ACCUM);
  assign ram_addr  = AW'({k_q, ptr_q});
  assign ram_wdata = cap_q[k_q];

  accel_sample_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  function automatic logic [SUM_W-1:0] sext(input logic [DATA_W-1:0] v);
    return {{AVG_LOG2{v[DATA_W-1]}}, v};
  endfunction

  // Running sum replaces the oldest sample with the newest; modular
  // arithmetic keeps it exact across any number of ptr wraps.
  always_comb begin
    for (int i = 0; i < N_AXES; i++) begin
      sum_d[i] = sum_q[i];
      if (ram_we && (k_q == KW'(i)))
        sum_d[i] = sum_q[i] + sext(ram_wdata) - sext(ram_rdata);
    end
  end

  // Per-axis result datapath, computed from the post-update sums so the
  // final ACCUM edge can load the output registers directly.
  for (genvar i = 0; i < N_AXES; i++) begin : g_lane
    logic [DATA_W-1:0]   avg;
    logic [AVG_LOG2-1:0] unused_frac;

    // Dropping the low bits of the two's-complement sum is an arithmetic
    // shift rounding toward minus infinity.
    assign avg         = sum_d[i][SUM_W-1:AVG_LOG2];
    assign unused_frac = sum_d[i][AVG_LOG2-1:0];

    assign avg_d[i] = avg;
    assign neg_d[i] = avg[DATA_W-1];
    // The most negative value has no positive twin; clamp to max.
    assign abs_d[i] = (avg == AVG_MIN) ? AVG_MAX :
                      (avg[DATA_W-1] ? -avg : avg);
    // Set above TH; with hysteresis a set flag holds until abs drops below TH_LO.
    assign over_d[i] = (abs_d[i] > TH) | (HYST_ON & over_q[i] & ~(abs_d[i] < TH_LO));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= '0;
      ptr_q       <= '0;
      fill_q      <= '0;
      cap_q       <= '0;
      for (int i = 0; i < N_AXES; i++) sum_q[i] <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      avg_q       <= '0;
      abs_q       <= '0;
      neg_q       <= '0;
      over_q      <= '0;
      filled_q    <= 1'b0;
      ovr_q       <= '0;
    end else begin
      out_valid_q <= 1'b0;
      for (int i = 0; i < N_AXES; i++) sum_q[i] <= sum_d[i];

      // Samples arriving while busy are dropped, never buffered.
      if (bus.sample_valid && !in_ready_q && (ovr_q != 8'hFF))
        ovr_q <= ovr_q + 8'd1;

      unique case (state_q)
        IDLE: begin
          if (bus.sample_valid) begin
            cap_q      <= bus.sample_data;
            k_q        <= '0;
            in_ready_q <= 1'b0;
            state_q    <= ACCUM;
          end
        end
        ACCUM: begin
          if (k_q == KW'(N_AXES - 1)) begin
            // Results are loaded on entry so they are valid throughout the
            // PUBLISH cycle alongside out_valid.
            state_q     <= PUBLISH;
            out_valid_q <= 1'b1;
            avg_q       <= avg_d;
            abs_q       <= abs_d;
            neg_q       <= neg_d;
            over_q      <= over_d;
            filled_q    <= filled_q | (fill_q == FW'(D - 1));
          end else begin
            k_q <= k_q + KW'(1);
          end
        end
        PUBLISH: begin
          ptr_q <= ptr_q + AVG_LOG2'(1);
          if (fill_q != FW'(D)) fill_q <= fill_q + FW'(1);
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.avg_data    = avg_q;
  assign bus.abs_data    = abs_q;
  assign bus.neg         = neg_q;
  assign bus.over        = over_q;
  assign bus.filled      = filled_q;
  assign bus.overrun_cnt = ovr_q;

endmodule

// File: tb/tb_accel_axis_filter.sv
// tb_accel_axis_filter: directed, table-driven bench for accel_axis_filter
// (default parameters). Table rows are one accepted sample each with the
// hand-computed results expected at the following out_valid; overrun and
// reset-mid-ACCUM are hand-written sequences.
module tb_accel_axis_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;

  accel_axis_filter_if #(.DATA_W(16), .N_AXES(3)) bus ();

  accel_axis_filter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  typedef struct {
    bit          rst;
    bit          chk;
    logic [15:0] x, y, z;
    logic [47:0] avg;
    logic [47:0] abs;
    logic [2:0]  neg;
    logic [2:0]  over;
    logic        filled;
  } vec_t;

  vec_t tbl[$];
  int   n_vec = 0;
  int   n_err = 0;

  function automatic vec_t mk(bit r, bit c, logic [15:0] x, logic [15:0] y, logic [15:0] z,
                              logic [15:0] ax, logic [15:0] ay, logic [15:0] az,
                              logic [15:0] bx, logic [15:0] by, logic [15:0] bz,
                              logic [2:0] ng, logic [2:0] ov, logic f);
    vec_t v;
    v.rst = r; v.chk = c; v.x = x; v.y = y; v.z = z;
    v.avg = {az, ay, ax};
    v.abs = {bz, by, bx};
    v.neg = ng; v.over = ov; v.filled = f;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
  endtask

  // Waits for in_ready, pulses one sample, returns at the negedge on which
  // out_valid is seen (or after a bounded wait).
  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    int w, lat;
    w = 0;
    while (!bus.in_ready && w < 20) begin @(negedge clk); w++; end
    if (!bus.in_ready) check("in_ready timeout", 64'(bus.in_ready), 64'd1);
    bus.sample_valid = 1'b1;
    bus.sample_data  = {z, y, x};
    @(negedge clk);
    bus.sample_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 12) begin @(negedge clk); lat++; end
    check("latency", 64'(lat), 64'd4);
  endtask

  initial begin
    int ov_cnt;
    logic [15:0] cap_x;

    // fill ramp
    tbl.push_back(mk(1,1,16'h0100,16'hFF00,16'h4000, 16'h0020,16'hFFE0,16'h0800, 16'h0020,16'h0020,16'h0800, 3'b010,3'b000,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h0040,16'hFFC0,16'h1000, 16'h0040,16'h0040,16'h1000, 3'b010,3'b000,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h0060,16'hFFA0,16'h1800, 16'h0060,16'h0060,16'h1800, 3'b010,3'b100,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h0080,16'hFF80,16'h2000, 16'h0080,16'h0080,16'h2000, 3'b010,3'b100,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h00A0,16'hFF60,16'h2800, 16'h00A0,16'h00A0,16'h2800, 3'b010,3'b100,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h00C0,16'hFF40,16'h3000, 16'h00C0,16'h00C0,16'h3000, 3'b010,3'b100,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h00E0,16'hFF20,16'h3800, 16'h00E0,16'h00E0,16'h3800, 3'b010,3'b100,1'b0));
    tbl.push_back(mk(0,1,16'h0100,16'hFF00,16'h4000, 16'h0100,16'hFF00,16'h4000, 16'h0100,16'h0100,16'h4000, 3'b010,3'b100,1'b1));
    // saturation of the most negative average
    tbl.push_back(mk(1,1,16'h8000,'0,'0, 16'hF000,'0,'0, 16'h1000,'0,'0, 3'b001,3'b000,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'hE000,'0,'0, 16'h2000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'hD000,'0,'0, 16'h3000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'hC000,'0,'0, 16'h4000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'hB000,'0,'0, 16'h5000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'hA000,'0,'0, 16'h6000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'h9000,'0,'0, 16'h7000,'0,'0, 3'b001,3'b001,1'b0));
    tbl.push_back(mk(0,1,16'h8000,'0,'0, 16'h8000,'0,'0, 16'h7FFF,'0,'0, 3'b001,3'b001,1'b1));
    // ptr wrap: 8 x 0x0080 then 8 x 0, avg steps by 0x10
    for (int n = 1; n <= 8; n++)
      tbl.push_back(mk(n == 1,1,16'h0080,'0,'0, 16'(16*n),'0,'0, 16'(16*n),'0,'0, 3'b000,3'b000,n == 8));
    for (int n = 1; n <= 8; n++)
      tbl.push_back(mk(0,1,'0,'0,'0, 16'(128-16*n),'0,'0, 16'(128-16*n),'0,'0, 3'b000,3'b000,1'b1));
    // threshold / hysteresis band
    for (int n = 1; n < 8; n++) tbl.push_back(mk(n == 1,0,16'h1001,'0,'0, '0,'0,'0, '0,'0,'0, '0,'0,1'b0));
    tbl.push_back(mk(0,1,16'h1001,'0,'0, 16'h1001,'0,'0, 16'h1001,'0,'0, 3'b000,3'b001,1'b1));
    for (int n = 1; n < 8; n++) tbl.push_back(mk(0,0,16'h0F80,'0,'0, '0,'0,'0, '0,'0,'0, '0,'0,1'b1));
`ifdef ACCEL_FILT_HYST_EN
    tbl.push_back(mk(0,1,16'h0F80,'0,'0, 16'h0F80,'0,'0, 16'h0F80,'0,'0, 3'b000,3'b001,1'b1));
`else
    tbl.push_back(mk(0,1,16'h0F80,'0,'0, 16'h0F80,'0,'0, 16'h0F80,'0,'0, 3'b000,3'b000,1'b1));
`endif
    for (int n = 1; n < 8; n++) tbl.push_back(mk(0,0,16'h0EFF,'0,'0, '0,'0,'0, '0,'0,'0, '0,'0,1'b1));
    tbl.push_back(mk(0,1,16'h0EFF,'0,'0, 16'h0EFF,'0,'0, 16'h0EFF,'0,'0, 3'b000,3'b000,1'b1));

    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // reset state
    check("rst in_ready",  64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst avg",       64'(bus.avg_data), 64'd0);
    check("rst abs",       64'(bus.abs_data), 64'd0);
    check("rst neg_over",  64'({bus.neg, bus.over}), 64'd0);
    check("rst filled",    64'(bus.filled), 64'd0);
    check("rst overrun",   64'(bus.overrun_cnt), 64'd0);

    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      send(tbl[i].x, tbl[i].y, tbl[i].z);
      if (tbl[i].chk) begin
        check($sformatf("v%0d avg", i),    64'(bus.avg_data), 64'(tbl[i].avg));
        check($sformatf("v%0d abs", i),    64'(bus.abs_data), 64'(tbl[i].abs));
        check($sformatf("v%0d neg", i),    64'(bus.neg),      64'(tbl[i].neg));
        check($sformatf("v%0d over", i),   64'(bus.over),     64'(tbl[i].over));
        check($sformatf("v%0d filled", i), 64'(bus.filled),   64'(tbl[i].filled));
      end
    end

    // overrun: second pulse one cycle after the first is dropped
    do_reset();
    bus.sample_valid = 1'b1;
    bus.sample_data  = {16'h0, 16'h0, 16'h0800};
    @(negedge clk);
    bus.sample_data  = {16'h0, 16'h0, 16'h7FF8};
    @(negedge clk);
    bus.sample_valid = 1'b0;
    ov_cnt = 0;
    cap_x  = '0;
    for (int c = 0; c < 8; c++) begin
      if (bus.out_valid) begin ov_cnt++; cap_x = bus.avg_data[15:0]; end
      @(negedge clk);
    end
    check("overrun one out_valid", 64'(ov_cnt), 64'd1);
    check("overrun avg_x",         64'(cap_x), 64'h0100);
    check("overrun cnt 1",         64'(bus.overrun_cnt), 64'd1);

    // hold sample_valid long enough for well over 255 drops
    bus.sample_valid = 1'b1;
    repeat (400) @(negedge clk);
    bus.sample_valid = 1'b0;
    repeat (8) @(negedge clk);
    check("overrun saturate", 64'(bus.overrun_cnt), 64'd255);

    // reset during ACCUM
    bus.sample_valid = 1'b1;
    bus.sample_data  = {16'h0, 16'h0, 16'h0400};
    @(negedge clk);
    bus.sample_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst in_ready",  64'(bus.in_ready), 64'd1);
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst avg",       64'(bus.avg_data), 64'd0);
    check("midrst abs",       64'(bus.abs_data), 64'd0);
    check("midrst flags",     64'({bus.neg, bus.over, bus.filled}), 64'd0);
    check("midrst overrun",   64'(bus.overrun_cnt), 64'd0);
    ov_cnt = 0;
    for (int c = 0; c < 6; c++) begin
      if (bus.out_valid) ov_cnt++;
      @(negedge clk);
    end
    check("midrst no out_valid", 64'(ov_cnt), 64'd0);
    send(16'h0400, 16'h0, 16'h0);
    check("midrst next avg", 64'(bus.avg_data), 64'h0080);
    check("midrst next filled", 64'(bus.filled), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
